// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 console UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  function automatic int unsigned calc_div(input int unsigned clk_freq_hz,
                                           input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while running, raises a one-cycle tick
// during the last cycle of every bit so the FSM advances on the boundary edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 217
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // The tick is registered from the next count, so it lines up with cnt_q == DIV-1.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (i_clear || !i_run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    done_d = (cnt_d == CNT_W'(DIV - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_bit_done = done_q;

endmodule

// File: rtl/uart_byte_emitter.sv
// Transmit-only 8N1 UART serializer for the SoC console; LSB first, line idles high.
module uart_byte_emitter
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq_hz = 50_000_000,
  parameter int unsigned baud_rate   = 230_400
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_uart_tx
);

  localparam int unsigned DIV   = calc_div(clk_freq_hz, baud_rate);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_div_check
    $error("uart_byte_emitter: clk_freq_hz / baud_rate must be at least 2");
  end
  if (FRAME_BITS != DATA_BITS + 2) begin : g_frame_check
    $error("uart_byte_emitter: frame must be start + data + one stop bit");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 bit_done;

  assign accept = i_valid && ready_q;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (state_q != IDLE),
    .i_clear    (accept),
    .o_bit_done (bit_done)
  );

  // Next-state and next-output; tx/ready are loaded one edge ahead so they come straight off flops.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = i_data;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d      = shreg_q[1];
            shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_byte_emitter.sv
// Bench for uart_byte_emitter: a DIV=4 instance for cycle-exact tracing and a
// default-rate instance; a line monitor decodes frames against a byte scoreboard.
module tb_uart_byte_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  uart_byte_emitter #(
    .clk_freq_hz(4),
    .baud_rate  (1)
  ) dut_a (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data_a),
    .i_valid  (valid_a),
    .o_ready  (ready_a),
    .o_uart_tx(tx_a)
  );

  uart_byte_emitter dut_b (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data_b),
    .i_valid  (valid_b),
    .o_ready  (ready_b),
    .o_uart_tx(tx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  // Expected line level for frame slot idx: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Mid-bit sampler; abandons the frame if reset is seen while decoding.
  task automatic rx_loop(input bit sel, input int div);
    logic [9:0] f;
    logic [7:0] e;
    bit         ab;
    int         w;
    forever begin
      do @(negedge clk); while (!(line(sel) === 1'b0 && !rst));
      ab = 1'b0;
      f  = '0;
      for (int n = 0; n < 10; n++) begin
        w = (n == 0) ? div / 2 : div;
        for (int c = 0; c < w; c++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
          if (ab) break;
        end
        if (ab) break;
        f[n] = line(sel);
      end
      if (!ab) begin
        check(sel ? "rx_b_start" : "rx_a_start", 32'(f[0]), 32'd0);
        check(sel ? "rx_b_stop" : "rx_a_stop", 32'(f[9]), 32'd1);
        if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
          check(sel ? "rx_b_unexpected" : "rx_a_unexpected", {24'd0, f[8:1]}, 32'hFFFF_FFFF);
        end else begin
          e = sel ? exp_b.pop_front() : exp_a.pop_front();
          check(sel ? "rx_b_byte" : "rx_a_byte", {24'd0, f[8:1]}, {24'd0, e});
        end
      end
    end
  endtask

  initial rx_loop(1'b0, 4);
  initial rx_loop(1'b1, 217);

  task automatic wait_ready(input bit sel, input int budget, input string tag, output int cyc);
    cyc = 0;
    while (!(sel ? ready_b : ready_a) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(sel ? ready_b : ready_a), 32'd1);
  endtask

  // Sends one byte on the DIV=4 instance and checks the line every cycle.
  task automatic send_trace_a(input logic [7:0] b);
    data_a  = b;
    valid_a = 1'b1;
    exp_a.push_back(b);
    @(negedge clk);
    valid_a = 1'b0;
    data_a  = ~b;
    for (int i = 0; i < 40; i++) begin
      check("trace_tx", 32'(tx_a), 32'(frame_bit(b, i / 4)));
      check("trace_busy", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    check("trace_ready_back", 32'(ready_a), 32'd1);
    check("trace_idle_tx", 32'(tx_a), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst     = 1'b1;
    valid_a = 1'b1;
    data_a  = 8'h5A;
    valid_b = 1'b0;
    data_b  = 8'h00;

    // Reset held with valid high: idle outputs, no frame until release.
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_ready", 32'(ready_a), 32'd1);
    end
    exp_a.push_back(8'h5A);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(ready_a), 32'd0);
    check("post_rst_start", 32'(tx_a), 32'd0);
    valid_a = 1'b0;
    wait_ready(1'b0, 60, "t1_done", cyc);

    // Single byte, DIV=4.
    send_trace_a(8'h55);

    // Default rate, 0xA3, total busy time.
    data_b  = 8'hA3;
    valid_b = 1'b1;
    exp_b.push_back(8'hA3);
    @(negedge clk);
    valid_b = 1'b0;
    data_b  = 8'h00;
    wait_ready(1'b1, 3000, "t3_done", cyc);
    check("t3_busy_cycles", 32'(cyc), 32'd2170);

    // Request while busy is dropped.
    data_a  = 8'h41;
    valid_a = 1'b1;
    exp_a.push_back(8'h41);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (4) @(negedge clk);
    data_a  = 8'h42;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("t4_still_busy", 32'(ready_a), 32'd0);
    wait_ready(1'b0, 60, "t4_done", cyc);
    for (int i = 0; i < 20; i++) begin
      check("t4_idle_tx", 32'(tx_a), 32'd1);
      check("t4_idle_ready", 32'(ready_a), 32'd1);
      @(negedge clk);
    end

    // Back-to-back with valid held high.
    data_a  = 8'h00;
    valid_a = 1'b1;
    exp_a.push_back(8'h00);
    exp_a.push_back(8'hFF);
    @(negedge clk);
    data_a = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      check("t5_tx", 32'(tx_a), (i < 36) ? 32'd0 : 32'd1);
      check("t5_busy", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    check("t5_gap_ready", 32'(ready_a), 32'd1);
    check("t5_gap_tx", 32'(tx_a), 32'd1);
    @(negedge clk);
    check("t5_second_start", 32'(tx_a), 32'd0);
    check("t5_second_busy", 32'(ready_a), 32'd0);
    valid_a = 1'b0;
    wait_ready(1'b0, 60, "t5_done", cyc);

    // Reset during data bit 3 of 0x0F.
    data_a  = 8'h0F;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (17) @(negedge clk);
    check("t6_pre_busy", 32'(ready_a), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("t6_async_tx", 32'(tx_a), 32'd1);
    check("t6_async_ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_trace_a(8'hC6);

    repeat (5) @(negedge clk);
    check("sb_a_drain", 32'(exp_a.size()), 32'd0);
    check("sb_b_drain", 32'(exp_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_byte_emitter.md
Name: uart_byte_emitter

Overview:
- Transmit-only 8N1 UART serializer used as the SoC console output.
- The CPU's IO write path presents one byte with a valid strobe. The block serializes it LSB-first on a single TX line at a fixed baud rate.
- A ready flag is exposed so software can poll busy status through the IO status word (busy = !o_ready).

Parameters:
- clk_freq_hz, 50000000, input clock frequency in Hz.
- baud_rate, 230400, line rate in bit/s.
- Derived constant DIV = clk_freq_hz / baud_rate, integer division (217 for the defaults). Elaboration must fail if DIV < 2.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous active-high reset.
- i_data  input  8  byte to send; sampled only on acceptance.
- i_valid  input  1  request strobe; may be a single-cycle pulse.
- o_ready  output  1  high = idle, a byte can be accepted.
- o_uart_tx  output  1  serial line; idles high.

Behaviour:
- Reset (async, i_rst=1):
  - o_uart_tx=1, o_ready=1, state IDLE, baud counter 0, bit index 0, shift register 0.
  - Takes effect immediately, even mid-frame; any partial frame is abandoned.
- Acceptance: at a rising edge where i_valid=1 and o_ready=1 (registered value before the edge).
  - Latch i_data into the shift register.
  - After that edge (call it edge k): o_ready=0, o_uart_tx=0 (start bit), state START, baud counter restarts.
- i_valid while o_ready=0 is ignored. The byte is dropped, and the in-flight frame is unaffected.
- Every bit lasts exactly DIV clock cycles. With acceptance at edge k:
  - start bit occupies edges k .. k+DIV.
  - data bit n (n=0..7, LSB first) occupies k+(1+n)*DIV .. k+(2+n)*DIV.
  - stop bit (1) occupies k+9*DIV .. k+10*DIV.
- At edge k+10*DIV: state IDLE, o_ready=1, o_uart_tx stays 1.
  - The earliest next acceptance is edge k+10*DIV+1, so the minimum frame-to-frame spacing is 10*DIV+1 cycles.
- States and transitions:
  - IDLE → START on acceptance.
  - START → DATA after DIV cycles.
  - DATA → DATA per bit, bit index 0..7.
  - DATA → STOP after bit 7 has completed DIV cycles.
  - STOP → IDLE after DIV cycles.
- Baud counter:
  - Width is $clog2(DIV).
  - Counts 0..DIV-1 and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
- o_uart_tx and o_ready are driven directly from flops (glitch-free).
- i_data changes after acceptance do not affect the frame in flight.
- No parity, no flow-control input; the SoC ties CTS high externally.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP};
  - localparams FRAME_BITS=10 and DATA_BITS=8;
  - the DIV computation function.
- One natural sub-module: uart_baud_tick. It owns the DIV counter, exposes a one-cycle bit_done tick, and takes a clear input driven on acceptance.
- Shift register, bit index and FSM stay in uart_byte_emitter.

Test Plan:
1. Reset values: assert i_rst for 3 cycles with i_valid=1 → o_uart_tx=1, o_ready=1 throughout; no frame starts until the first edge after release.
2. Single byte 0x55 with clk_freq_hz=4, baud_rate=1 (DIV=4), 1-cycle valid pulse at edge k:
   - o_ready=0 for exactly 40 cycles;
   - line pattern 0,1,0,1,0,1,0,1,0,1, each held 4 cycles;
   - o_ready=1 at edge k+40.
3. Byte 0xA3 at default parameters (DIV=217):
   - sampling the line mid-bit at k+217*n+108 for n=0..9 yields 0,1,1,0,0,0,1,0,1,1;
   - total busy time is 2170 cycles.
4. Busy drop: send 0x41, then pulse i_valid with 0x42 five cycles later → only 0x41 is emitted; the line is idle-high after the stop bit and o_ready stays 1.
5. Back-to-back: hold i_valid=1 with 0x00 then 0xFF (DIV=4) → second start bit begins at edge k+41; 0x00 gives 36 low cycles then 4 high.
6. Mid-frame reset: assert i_rst at data bit 3 of 0x0F → o_uart_tx=1 and o_ready=1 asynchronously before the next clock edge; a new byte accepted after release produces a full, correct frame.
